// File: rtl/dpram_be_sync.sv
// Single-clock true dual-port RAM with per-byte write enables and per-port clock enables.
// A same-address collision gives port A priority, and an optional clear sweep runs after reset.
module dpram_be_sync #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter string       INIT_FILE      = "",
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0]  CLEAR_VALUE    = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ce_a,
  input  logic                    ce_b,
  input  logic                    wren_a,
  input  logic                    wren_b,
  input  logic [DATA_WIDTH/8-1:0] byteena_a,
  input  logic [DATA_WIDTH/8-1:0] byteena_b,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    busy
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   q_a_q, q_a_d;
  logic [DATA_WIDTH-1:0]   q_b_q, q_b_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    acc_ok_c;
  logic                    wr_a_c, wr_b_c, coll_c;
  logic [NB-1:0]           be_a_c, be_b_c;
  logic [DATA_WIDTH-1:0]   rd_a_c, rd_b_c;

  // Port qualification: user requests only count in IDLE with reset low.
  always_comb begin
    acc_ok_c = !reset && (state_q == IDLE);
    wr_a_c   = acc_ok_c && ce_a && wren_a;
    wr_b_c   = acc_ok_c && ce_b && wren_b;
    coll_c   = wr_a_c && wr_b_c && (address_a == address_b);
    be_a_c   = wr_a_c ? byteena_a : '0;
    be_b_c   = wr_b_c ? byteena_b : '0;
    rd_a_c   = mem_q[address_a];
    rd_b_c   = mem_q[address_b];
  end

  // Next-state logic: sweep control and per-lane read-data selection.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    q_a_d   = q_a_q;
    q_b_d   = q_b_q;
    case (state_q)
      CLEAR: begin
        busy_d = 1'b1;
        if (clr_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_d = clr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
          if (ce_a) begin
            if (be_a_c[i])                q_a_d[8*i +: 8] = data_a[8*i +: 8];
            else if (coll_c && be_b_c[i]) q_a_d[8*i +: 8] = data_b[8*i +: 8];
            else                          q_a_d[8*i +: 8] = rd_a_c[8*i +: 8];
          end
          if (ce_b) begin
            if (coll_c && be_a_c[i])      q_b_d[8*i +: 8] = data_a[8*i +: 8];
            else if (be_b_c[i])           q_b_d[8*i +: 8] = data_b[8*i +: 8];
            else                          q_b_d[8*i +: 8] = rd_b_c[8*i +: 8];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      busy_q  <= CLEAR_ON_RESET;
      clr_q   <= '0;
      q_a_q   <= '0;
      q_b_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      q_a_q   <= q_a_d;
      q_b_q   <= q_b_d;
    end
  end

  // Storage: port A is written last so it wins lanes both ports enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_q] <= {NB{CLEAR_VALUE}};
      end else begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (be_b_c[i]) mem_q[address_b][8*i +: 8] <= data_b[8*i +: 8];
        end
        for (int unsigned i = 0; i < NB; i++) begin
          if (be_a_c[i]) mem_q[address_a][8*i +: 8] <= data_a[8*i +: 8];
        end
      end
    end
  end

  assign q_a  = q_a_q;
  assign q_b  = q_b_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dpram_be_sync.sv
// Directed bench for dpram_be_sync (16-bit words, 16 entries, clear value A5).
module tb_dpram_be_sync;

  logic        clock;
  logic        reset;
  logic        ce_a, ce_b, wren_a, wren_b;
  logic [1:0]  byteena_a, byteena_b;
  logic [3:0]  address_a, address_b;
  logic [15:0] data_a, data_b;
  logic [15:0] q_a, q_b;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dpram_be_sync #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_FILE(""),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)
  ) dut (
    .clock(clock), .reset(reset),
    .ce_a(ce_a), .ce_b(ce_b), .wren_a(wren_a), .wren_b(wren_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b),
    .q_a(q_a), .q_b(q_b), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ports_idle();
    ce_a = 0; ce_b = 0; wren_a = 0; wren_b = 0;
    byteena_a = 2'b00; byteena_b = 2'b00;
    address_a = 4'd0; address_b = 4'd0;
    data_a = 16'h0; data_b = 16'h0;
  endtask

  task automatic test_reset();
    int cnt;
    ports_idle();
    reset = 1;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++; if (q_a !== 16'h0) begin errors++; $display("FAIL reset_q_a got %h exp 0000", q_a); end
    checks++; if (q_b !== 16'h0) begin errors++; $display("FAIL reset_q_b got %h exp 0000", q_b); end
    reset = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++; if (cnt !== 16) begin errors++; $display("FAIL sweep_len got %0d exp 16", cnt); end
    ce_b = 1;
    for (int k = 0; k < 16; k++) begin
      address_b = 4'(k);
      tick();
      checks++;
      if (q_b !== 16'hA5A5) begin errors++; $display("FAIL clear_word[%0d] got %h exp a5a5", k, q_b); end
    end
    ports_idle();
  endtask

  task automatic test_mid_sweep();
    int cnt;
    reset = 1;
    tick();
    reset = 0;
    // Keep both ports hammering writes for the whole busy window.
    ce_a = 1; wren_a = 1; byteena_a = 2'b11; data_a = 16'h0000;
    ce_b = 1; wren_b = 1; byteena_b = 2'b11; data_b = 16'h1111;
    for (int k = 0; k < 7; k++) begin
      address_a = 4'(k); address_b = 4'(15 - k);
      tick();
    end
    reset = 1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy got %b exp 1", busy); end
    reset = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      address_a = 4'(cnt); address_b = 4'(15 - cnt);
      tick();
      cnt++;
    end
    checks++; if (cnt !== 16) begin errors++; $display("FAIL mid_sweep_len got %0d exp 16", cnt); end
    ports_idle();
    ce_a = 1; ce_b = 1;
    for (int k = 0; k < 8; k++) begin
      address_a = 4'(k); address_b = 4'(k + 8);
      tick();
      checks++;
      if (q_a !== 16'hA5A5) begin errors++; $display("FAIL busy_write_a[%0d] got %h exp a5a5", k, q_a); end
      checks++;
      if (q_b !== 16'hA5A5) begin errors++; $display("FAIL busy_write_b[%0d] got %h exp a5a5", k + 8, q_b); end
    end
    ports_idle();
  endtask

  task automatic test_byte_enables();
    ce_a = 1; wren_a = 1; address_a = 4'd3; data_a = 16'h1234; byteena_a = 2'b11;
    tick();
    checks++; if (q_a !== 16'h1234) begin errors++; $display("FAIL be_full got %h exp 1234", q_a); end
    data_a = 16'hFF00; byteena_a = 2'b10;
    tick();
    checks++; if (q_a !== 16'hFF34) begin errors++; $display("FAIL be_upper got %h exp ff34", q_a); end
    ports_idle();
    ce_b = 1; address_b = 4'd3;
    tick();
    checks++; if (q_b !== 16'hFF34) begin errors++; $display("FAIL be_readback got %h exp ff34", q_b); end
    ports_idle();
  endtask

  task automatic test_cross_port();
    ce_a = 1; wren_a = 1; address_a = 4'd5; data_a = 16'h0001; byteena_a = 2'b11;
    tick();
    data_a = 16'hBEEF;
    ce_b = 1; address_b = 4'd5;
    tick();
    checks++; if (q_b !== 16'h0001) begin errors++; $display("FAIL cross_old got %h exp 0001", q_b); end
    checks++; if (q_a !== 16'hBEEF) begin errors++; $display("FAIL cross_own got %h exp beef", q_a); end
    ce_a = 0; wren_a = 0;
    tick();
    checks++; if (q_b !== 16'hBEEF) begin errors++; $display("FAIL cross_new got %h exp beef", q_b); end
    ports_idle();
  endtask

  task automatic test_collision();
    ce_a = 1; wren_a = 1; address_a = 4'd9; data_a = 16'h0000; byteena_a = 2'b11;
    tick();
    data_a = 16'hAAAA; byteena_a = 2'b01;
    ce_b = 1; wren_b = 1; address_b = 4'd9; data_b = 16'hBBBB; byteena_b = 2'b11;
    tick();
    checks++; if (q_a !== 16'hBBAA) begin errors++; $display("FAIL coll_q_a got %h exp bbaa", q_a); end
    checks++; if (q_b !== 16'hBBAA) begin errors++; $display("FAIL coll_q_b got %h exp bbaa", q_b); end
    ports_idle();
    ce_a = 1; address_a = 4'd9;
    tick();
    checks++; if (q_a !== 16'hBBAA) begin errors++; $display("FAIL coll_stored got %h exp bbaa", q_a); end
    ports_idle();
  endtask

  task automatic test_ce_gating();
    ce_a = 1; wren_a = 1; address_a = 4'd7; data_a = 16'h1234; byteena_a = 2'b11;
    tick();
    ports_idle();
    ce_b = 1; address_b = 4'd7;
    tick();
    checks++; if (q_b !== 16'h1234) begin errors++; $display("FAIL ce_setup got %h exp 1234", q_b); end
    ce_b = 0; wren_b = 1; data_b = 16'h5555; byteena_b = 2'b11;
    ce_a = 1; wren_a = 1; byteena_a = 2'b11;
    for (int k = 0; k < 4; k++) begin
      address_a = 4'(k + 10); data_a = 16'(16'hC000 + k);
      tick();
      checks++;
      if (q_b !== 16'h1234) begin errors++; $display("FAIL ce_hold[%0d] got %h exp 1234", k, q_b); end
    end
    ports_idle();
    ce_b = 1; address_b = 4'd7;
    tick();
    checks++; if (q_b !== 16'h1234) begin errors++; $display("FAIL ce_mem got %h exp 1234", q_b); end
    ports_idle();
  endtask

  task automatic test_back_to_back();
    ce_a = 1; wren_a = 1; address_a = 4'd10; data_a = 16'h1111; byteena_a = 2'b11;
    ce_b = 1; wren_b = 1; address_b = 4'd11; data_b = 16'h2222; byteena_b = 2'b11;
    tick();
    // Write with no lanes enabled still performs the read.
    data_a = 16'hFFFF; byteena_a = 2'b00;
    wren_b = 0; address_b = 4'd10;
    tick();
    checks++; if (q_a !== 16'h1111) begin errors++; $display("FAIL be_zero got %h exp 1111", q_a); end
    checks++; if (q_b !== 16'h1111) begin errors++; $display("FAIL indep_a got %h exp 1111", q_b); end
    wren_a = 0; address_a = 4'd11;
    tick();
    checks++; if (q_a !== 16'h2222) begin errors++; $display("FAIL indep_b got %h exp 2222", q_a); end
    ports_idle();
  endtask

  initial begin
    reset = 1;
    ports_idle();
    test_reset();
    test_mid_sweep();
    test_byte_enables();
    test_cross_port();
    test_collision();
    test_ce_gating();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
